// File: rtl/controle_varredura_matriz_pkg.sv
// Shared definitions for the LED matrix scan controller: source codes
// (also used by the game control unit), FSM states and default geometry.
package pkg_matriz;

  localparam logic [1:0] FONTE_BOTOES  = 2'b00;
  localparam logic [1:0] FONTE_MEMORIA = 2'b01;
  localparam logic [1:0] FONTE_APAGADO = 2'b11;

  localparam int LINHAS_PADRAO  = 4;
  localparam int COLUNAS_PADRAO = 4;

  typedef enum logic [2:0] {
    INICIAL = 3'd0,
    CARREGA = 3'd1,
    ACENDE  = 3'd2,
    APAGA   = 3'd3
  } estado_t;

endpackage

// File: rtl/controle_varredura_matriz_temporizador.sv
// Up-counter that pulses fim on its last count (LIMITE-1) and wraps to zero;
// used for both the row-lit time and the dead time between rows.
module temporizador_varredura #(
  parameter int LIMITE = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int LARGURA = $clog2(LIMITE + 1);

  logic [LARGURA-1:0] contagem;

  assign fim = conta && (contagem == LARGURA'(LIMITE - 1));

  // NOTE: sequential state is written with <= so every register samples
  // pre-edge values; blocking = here would create order-dependent races.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)           contagem <= '0;
    else if (zera || fim) contagem <= '0;
    else if (conta)       contagem <= contagem + LARGURA'(1);
  end

endmodule

// File: rtl/controle_varredura_matriz.sv
// Row-by-row scan controller for the LED matrix: latches one image per frame
// from the buttons or the sequence memory, lights each row, then blanks it.
module controle_varredura_matriz
  import pkg_matriz::*;
#(
  parameter int LINHAS       = LINHAS_PADRAO,
  parameter int COLUNAS      = COLUNAS_PADRAO,
  parameter int CICLOS_LINHA = 50000,
  parameter int CICLOS_APAGA = 500
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        habilita,
  input  logic [1:0]                  fonte_sel,
  input  logic [LINHAS*COLUNAS-1:0]   dados_memoria,
  input  logic [LINHAS*COLUNAS-1:0]   dados_botoes,
  output logic [LINHAS-1:0]           linhas,
  output logic [COLUNAS-1:0]          colunas,
  output logic                        fim_quadro,
  output logic [1:0]                  fonte_ativa,
  output logic [$clog2(LINHAS)-1:0]   db_linha,
  output logic [2:0]                  db_estado
);

  localparam int LARG_LINHA = $clog2(LINHAS);
  localparam logic [LARG_LINHA-1:0] ULTIMA_LINHA = LARG_LINHA'(LINHAS - 1);

  estado_t                 estado, proximo;
  logic [LARG_LINHA-1:0]   linha;
  logic [LINHAS*COLUNAS-1:0] quadro;
  logic contaLinha, contaApaga, fimLinha, fimApaga, ultimaLinha;

  assign contaLinha  = habilita && (estado == ACENDE);
  assign contaApaga  = habilita && (estado == APAGA);
  assign ultimaLinha = (linha == ULTIMA_LINHA);
  assign db_linha    = linha;

  temporizador_varredura #(.LIMITE(CICLOS_LINHA)) uTempLinha (
    .clock (clock),
    .reset (reset),
    .zera  (!contaLinha),
    .conta (contaLinha),
    .fim   (fimLinha)
  );

  temporizador_varredura #(.LIMITE(CICLOS_APAGA)) uTempApaga (
    .clock (clock),
    .reset (reset),
    .zera  (!contaApaga),
    .conta (contaApaga),
    .fim   (fimApaga)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= INICIAL;
    else        estado <= proximo;
  end

  // NOTE: the frame buffer is a handful of flops, not a RAM, so it is cleared
  // on reset like the rest of the state; a real memory array would not be.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      linha       <= '0;
      quadro      <= '0;
      fonte_ativa <= FONTE_APAGADO;
    end else if (!habilita) begin
      linha <= '0;
    end else if (estado == CARREGA) begin
      linha <= '0;
      unique case (fonte_sel)
        FONTE_BOTOES:  quadro <= dados_botoes;
        FONTE_MEMORIA: quadro <= dados_memoria;
        default:       quadro <= '0;
      endcase
      fonte_ativa <= (fonte_sel == FONTE_BOTOES || fonte_sel == FONTE_MEMORIA)
                     ? fonte_sel : FONTE_APAGADO;
    end else if (estado == APAGA && fimApaga && !ultimaLinha) begin
      linha <= linha + LARG_LINHA'(1);
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    proximo    = estado;
    linhas     = '0;
    colunas    = '0;
    fim_quadro = 1'b0;
    db_estado  = 3'd7;
    case (estado)
      INICIAL: begin
        db_estado = 3'd0;
        proximo   = CARREGA;
      end
      CARREGA: begin
        db_estado = 3'd1;
        proximo   = ACENDE;
      end
      ACENDE: begin
        db_estado = 3'd2;
        linhas    = LINHAS'(1) << linha;
        colunas   = quadro[linha*COLUNAS +: COLUNAS];
        if (fimLinha) proximo = APAGA;
      end
      APAGA: begin
        db_estado = 3'd3;
        if (fimApaga) begin
          if (ultimaLinha) begin
            fim_quadro = 1'b1;
            proximo    = CARREGA;
          end else begin
            proximo = ACENDE;
          end
        end
      end
      default: proximo = INICIAL;
    endcase
    // Disabling blanks the matrix in the same cycle and parks the FSM.
    if (!habilita) begin
      proximo    = INICIAL;
      linhas     = '0;
      colunas    = '0;
      fim_quadro = 1'b0;
    end
  end

endmodule

// File: doc/controle_varredura_matriz.md
Name: controle_varredura_matriz

Overview:
Scan controller that multiplexes the LED matrix row by row. It shares the matrix between two image sources: the sequence memory and the player's buttons. The source is picked by the 2-bit source select driven by the game control unit. The selected image is latched once per frame, each row is driven for a fixed time, and a dead-time gap follows each row to prevent ghosting.

Parameters:
LINHAS, 4, number of matrix rows
COLUNAS, 4, number of matrix columns
CICLOS_LINHA, 50000, clock cycles each row is lit (>=1)
CICLOS_APAGA, 500, clock cycles of dead time after each row (>=1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; clears all state
habilita  in  1  scan enable; low blanks the matrix and parks the FSM
fonte_sel  in  2  00 = buttons, 01 = memory, 10/11 = blank
dados_memoria  in  LINHAS*COLUNAS  memory image; bit r*COLUNAS+c = row r, column c
dados_botoes  in  LINHAS*COLUNAS  button image; same bit layout
linhas  out  LINHAS  one-hot row drive, active high
colunas  out  COLUNAS  column data for the active row, active high
fim_quadro  out  1  one-cycle pulse at end of frame
fonte_ativa  out  2  source latched for the current frame
db_linha  out  $clog2(LINHAS)  current row index
db_estado  out  3  state code (debug)

Behaviour:
- Reset (reset=0, asynchronous):
  - state INICIAL; row counter, timer and frame buffer cleared.
  - linhas=0, colunas=0, fim_quadro=0, fonte_ativa=11, db_linha=0, db_estado=0.
- FSM states and db_estado codes: INICIAL=0, CARREGA=1, ACENDE=2, APAGA=3.
- INICIAL: outputs blank; when habilita=1, go to CARREGA.
- CARREGA (exactly 1 cycle):
  - frame buffer <= dados_botoes if fonte_sel=00; dados_memoria if fonte_sel=01; all zeros otherwise.
  - fonte_ativa <= fonte_sel, except 10 is reported as 11.
  - row <= 0, timer <= 0; go to ACENDE.
- ACENDE:
  - linhas = one-hot(row); colunas = buffer[row*COLUNAS +: COLUNAS].
  - timer counts 0..CICLOS_LINHA-1, so the row is lit exactly CICLOS_LINHA cycles.
  - at the final count: timer <= 0, go to APAGA.
- APAGA:
  - linhas=0, colunas=0 for exactly CICLOS_APAGA cycles.
  - at the final count, if row<LINHAS-1: row <= row+1, timer <= 0, go to ACENDE. No reload, so the frame buffer is unchanged.
  - at the final count, if row=LINHAS-1: fim_quadro=1 for that one cycle, then go to CARREGA.
- Frame period: LINHAS*(CICLOS_LINHA+CICLOS_APAGA)+1 cycles.
- fonte_sel, dados_memoria and dados_botoes are sampled only in CARREGA. Changes mid-frame take effect on the next frame, so no torn images.
- habilita=0 in any state:
  - linhas, colunas and fim_quadro are forced to 0 combinationally in the same cycle.
  - next state is INICIAL; row and timer are cleared.
  - fonte_ativa holds its value.
- habilita returning to 1: sequence is INICIAL -> CARREGA -> ACENDE, restarting at row 0.
- Reset asserted mid-operation: outputs drop to reset values immediately, without waiting for a clock edge.
- Timer width: $clog2(max(CICLOS_LINHA, CICLOS_APAGA)+1); no overflow is possible.
- Row counter wraps only through CARREGA, never by arithmetic overflow.
- Unreachable state encodings recover to INICIAL; db_estado=7 in that case.

Decomposition:
- Shared package pkg_matriz holds:
  - source codes FONTE_BOTOES=2'b00, FONTE_MEMORIA=2'b01, FONTE_APAGADO=2'b11, also used by the game control unit;
  - the FSM state constants;
  - default LINHAS and COLUNAS.
- One natural sub-module, temporizador_varredura: parameterised up-counter with zera and conta inputs and a fim output, reused for both row-lit and dead-time timing.

Test Plan (LINHAS=4, COLUNAS=4, CICLOS_LINHA=3, CICLOS_APAGA=1):
- Release reset with habilita=1, fonte_sel=01, dados_memoria=16'hA5C3 -> colunas is 3, C, 5, A on linhas 0001, 0010, 0100, 1000; each row lit 3 cycles, followed by 1 blank cycle.
- Free-run for 3 frames -> fim_quadro high for exactly 1 cycle every 17 cycles, coincident with the last APAGA of row 3.
- In row 1, switch fonte_sel to 00 with dados_botoes=16'h000F -> current frame still shows C/5/A; next CARREGA sets fonte_ativa=00; row0 colunas=F, rows 1-3 colunas=0.
- fonte_sel=10 -> fonte_ativa=11, colunas=0 in all rows, linhas still scan one-hot.
- Drop habilita during ACENDE row 2 -> linhas=0 and colunas=0 in the same cycle, db_estado=0 next cycle; re-raise -> 1 CARREGA cycle, then row 0 lit.
- Assert reset between clock edges during APAGA row 3 -> outputs and db_estado=0 immediately, fim_quadro never pulses, fonte_ativa=11.
